// File: rtl/bcd_serial_add_ctrl_if.sv
// Bundle of the start/operand request, shared digit-adder link and result signals.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                start;
  logic [4*DIGITS-1:0] a_bcd;
  logic [4*DIGITS-1:0] b_bcd;
  logic                cin;
  logic [3:0]          dig_a;
  logic [3:0]          dig_b;
  logic                dig_cin;
  logic [3:0]          dig_s;
  logic                dig_cout;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] sum_bcd;
  logic                cout;
  logic                err;
  logic [1:0]          state_dbg;

  // start is a request sampled only while idle; it is neither queued nor
  // acknowledged, and done pulses for exactly one cycle per accepted request.
  modport slave (
    input  start, a_bcd, b_bcd, cin, dig_s, dig_cout,
    output dig_a, dig_b, dig_cin, busy, done, sum_bcd, cout, err, state_dbg
  );

  modport master (
    output start, a_bcd, b_bcd, cin, dig_s, dig_cout,
    input  dig_a, dig_b, dig_cin, busy, done, sum_bcd, cout, err, state_dbg
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer that reuses one external single-digit BCD adder to add
// two DIGITS-wide packed BCD operands, least-significant digit first.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 3
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset_n,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_carry;
  logic                   r_err_acc;
  logic [DIGITS-1:0][3:0] r_a;
  logic [DIGITS-1:0][3:0] r_b;
  logic [DIGITS-1:0][3:0] r_slots;
  logic [DIGITS-1:0][3:0] r_sum;
  logic                   r_cout;
  logic                   r_err;

  logic [3:0]             w_a_dig;
  logic [3:0]             w_b_dig;
  logic                   w_last;
  logic                   w_bad;

  assign w_a_dig = r_a[r_idx];
  assign w_b_dig = r_b[r_idx];
  assign w_last  = (r_idx == IDX_W'(DIGITS - 1));
  assign w_bad   = (w_a_dig > 4'd9) | (w_b_dig > 4'd9);

  assign bus.sum_bcd   = r_sum;
  assign bus.cout      = r_cout;
  assign bus.err       = r_err;
  assign bus.state_dbg = r_state;

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.dig_a   = 4'd0;
    bus.dig_b   = 4'd0;
    bus.dig_cin = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_ADD;
        end
      end
      S_ADD: begin
        bus.dig_a   = w_a_dig;
        bus.dig_b   = w_b_dig;
        bus.dig_cin = r_carry;
        bus.busy    = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Invalid digits go through the adder untouched; only err records them.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_err_acc <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_slots   <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a       <= bus.a_bcd;
            r_b       <= bus.b_bcd;
            r_carry   <= bus.cin;
            r_idx     <= '0;
            r_err_acc <= 1'b0;
          end
        end
        S_ADD: begin
          r_slots[r_idx] <= bus.dig_s;
          r_carry        <= bus.dig_cout;
          r_err_acc      <= r_err_acc | w_bad;
          if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_sum  <= r_slots;
          r_cout <= r_carry;
          r_err  <= r_err_acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed/random bench for bcd_serial_add_ctrl with a behavioural digit adder
// and an expected-result queue checked when done is observed.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int RW     = W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .MAX10_CLK1_50 (clk),
    .reset_n       (rst_n),
    .bus           (bus.slave)
  );

  // Shared single-digit BCD adder: binary sum, +6 correction above 9.
  logic [4:0] ad_s;
  always_comb begin
    ad_s = {1'b0, bus.dig_a} + {1'b0, bus.dig_b} + {4'd0, bus.dig_cin};
    if (ad_s > 5'd9) begin
      bus.dig_cout = 1'b1;
      bus.dig_s    = 4'(ad_s + 5'd6);
    end else begin
      bus.dig_cout = 1'b0;
      bus.dig_s    = ad_s[3:0];
    end
  end

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [4:0] dadd(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (s > 5'd9) return {1'b1, 4'(s + 5'd6)};
    return s;
  endfunction

  // Result packed as {err, cout, sum}.
  function automatic logic [RW-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] s;
    logic         cy;
    logic         e;
    logic [4:0]   r;
    s  = '0;
    cy = c;
    e  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      r = dadd(a[4*i +: 4], b[4*i +: 4], cy);
      s[4*i +: 4] = r[3:0];
      cy = r[4];
      e  = e | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end
    return {e, cy, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit poke);
    logic [RW-1:0] exp_r;
    logic          carry;
    logic [4:0]    r;
    int            cyc;
    carry       = c;
    bus.a_bcd   = a;
    bus.b_bcd   = b;
    bus.cin     = c;
    bus.start   = 1'b1;
    exp_q.push_back(ref_add(a, b, c));
    tick();
    bus.start = 1'b0;
    bus.a_bcd = W'($urandom);
    bus.b_bcd = W'($urandom);
    bus.cin   = 1'($urandom_range(0, 1));
    for (int i = 0; i < DIGITS; i++) begin
      chk("busy_add", bus.busy, 1);
      chk("done_add", bus.done, 0);
      chk("dig_a", bus.dig_a, a[4*i +: 4]);
      chk("dig_b", bus.dig_b, b[4*i +: 4]);
      chk("dig_cin", bus.dig_cin, carry);
      if (i == 0) chk("sum_hold", bus.sum_bcd, last_res[W-1:0]);
      r     = dadd(a[4*i +: 4], b[4*i +: 4], carry);
      carry = r[4];
      bus.start = poke;
      tick();
    end
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4) begin
      tick();
      cyc++;
    end
    chk("done_latency", cyc, 0);
    chk("busy_done", bus.busy, 1);
    chk("dig_a_done", bus.dig_a, 0);
    tick();
    exp_r = exp_q.pop_front();
    chk("sum_bcd", bus.sum_bcd, exp_r[W-1:0]);
    chk("cout", bus.cout, exp_r[W]);
    chk("err", bus.err, exp_r[W+1]);
    chk("done_after", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    last_res = exp_r;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.start = 1'b0;
    bus.a_bcd = '0;
    bus.b_bcd = '0;
    bus.cin   = 1'b0;
    last_res  = '0;

    repeat (2) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum_bcd, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dig_a", bus.dig_a, 0);
    chk("rst_dig_b", bus.dig_b, 0);
    chk("rst_dig_cin", bus.dig_cin, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", bus.busy, 0);

    run_op(W'(12'h123), W'(12'h456), 1'b0, 1'b0);
    run_op(W'(12'h999), W'(12'h001), 1'b0, 1'b0);
    run_op(W'(12'h999), W'(12'h999), 1'b1, 1'b0);
    run_op(W'(12'h1A2), W'(12'h000), 1'b0, 1'b0);
    run_op(W'(12'h001), W'(12'h001), 1'b0, 1'b0);
    run_op(W'(12'h250), W'(12'h375), 1'b0, 1'b1);
    repeat (3) tick();
    chk("idle_hold_sum", bus.sum_bcd, last_res[W-1:0]);
    chk("idle_done", bus.done, 0);

    // Abort mid-operation with reset.
    bus.a_bcd = W'(12'h555);
    bus.b_bcd = W'(12'h444);
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sum", bus.sum_bcd, 0);
    chk("abort_cout", bus.cout, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_dig_a", bus.dig_a, 0);
    repeat (DIGITS + 2) begin
      tick();
      chk("abort_no_done", bus.done, 0);
    end
    last_res = '0;
    rst_n = 1'b1;
    run_op(W'(12'h087), W'(12'h014), 1'b1, 1'b0);

    repeat (6) begin
      ra = '0;
      rb = '0;
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
